regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the N-way superscalar RISC-V core, replacing the fixed 2-write/4-read file. All writes are clocked. Reads are combinational, with optional same-cycle write-to-read bypass. An integrated busy scoreboard tracks registers with in-flight producers. It sits between the decode/issue stage (read ports and scoreboard set) and writeback (write ports and scoreboard clear).

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_scoreboard.sv | 39 +++
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package regfile_pkg;
  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);
  // Widest port group the priority helper can resolve (8 write ports).
  localparam int MAXP     = 8;

  typedef logic [AW_DEF-1:0] reg_idx_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } match_t;

  // Highest-index set bit wins: the highest port carries the youngest instruction.
  function automatic match_t highest_match(input logic [MAXP-1:0] m);
    match_t r;
    r = '0;
    for (int i = 0; i < MAXP; i++) begin
      if (m[i]) begin
        r.hit = 1'b1;
        r.idx = 3'(i);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bit per register: set on issue, cleared on writeback, issue wins a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int NSLOT = 2,
  parameter int AW    = $clog2(NREG),
  parameter int NRD   = 2*NSLOT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NSLOT-1:0]          iss_en,
  input  logic [NSLOT-1:0][AW-1:0]  iss_addr,
  input  logic [NSLOT-1:0]          wr_en,
  input  logic [NSLOT-1:0][AW-1:0]  wr_addr,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  output logic [NRD-1:0]            rd_busy
);
  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NSLOT; i++)
      if (wr_en[i]) busy_d[wr_addr[i]] = 1'b0;
    // Sets applied after clears so a younger producer keeps the register busy.
    for (int i = 0; i < NSLOT; i++)
      if (iss_en[i]) busy_d[iss_addr[i]] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign rd_busy[p] = busy_q[rd_addr[p]];
  end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised N-way register file: clocked writes, combinational reads with
// optional writeback bypass, write collision flag and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NSLOT  = 2,
  parameter bit BYPASS = 1'b1,
  parameter int AW     = $clog2(NREG)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NSLOT-1:0]              wr_en,
  input  logic [NSLOT-1:0][AW-1:0]      wr_addr,
  input  logic [NSLOT-1:0][XLEN-1:0]    wr_data,
  input  logic [2*NSLOT-1:0][AW-1:0]    rd_addr,
  output logic [2*NSLOT-1:0][XLEN-1:0]  rd_data,
  output logic [2*NSLOT-1:0]            rd_busy,
  input  logic [NSLOT-1:0]              iss_en,
  input  logic [NSLOT-1:0][AW-1:0]      iss_addr,
  output logic                          wr_collide
);
  localparam int NRD = 2*NSLOT;

  logic [NREG-1:0][XLEN-1:0] mem_q, mem_d;
  logic [MAXP-1:0][XLEN-1:0] wd_x;
  logic [NRD-1:0]            sb_busy;

  always_comb begin
    wd_x = '0;
    for (int i = 0; i < NSLOT; i++) wd_x[i] = wr_data[i];
  end

  always_comb begin
    logic [MAXP-1:0] m;
    match_t          hm;
    m     = '0;
    hm    = '0;
    mem_d = mem_q;
    // x0 is skipped so it stays at its reset value of zero.
    for (int r = 1; r < NREG; r++) begin
      m = '0;
      for (int i = 0; i < NSLOT; i++) m[i] = wr_en[i] && (wr_addr[i] == AW'(r));
      hm = highest_match(m);
      if (hm.hit) mem_d[r] = wd_x[hm.idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '0;
    else        mem_q <= mem_d;
  end

  always_comb begin
    wr_collide = 1'b0;
    for (int i = 0; i < NSLOT; i++)
      for (int j = i + 1; j < NSLOT; j++)
        if (wr_en[i] && wr_en[j] && (wr_addr[i] == wr_addr[j]) && (wr_addr[i] != '0))
          wr_collide = 1'b1;
  end

  regfile_scoreboard #(.NREG(NREG), .NSLOT(NSLOT), .AW(AW), .NRD(NRD)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (sb_busy)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [MAXP-1:0] m;
    match_t          hm;
    logic            byp;
    always_comb begin
      m = '0;
      for (int i = 0; i < NSLOT; i++)
        m[i] = wr_en[i] && (wr_addr[i] == rd_addr[p]) && (rd_addr[p] != '0);
    end
    assign hm  = highest_match(m);
    // Bypass is held off in reset so every read returns zero while rst_n is low.
    assign byp = BYPASS && rst_n && hm.hit;
    assign rd_data[p] = byp ? wd_x[hm.idx] : mem_q[rd_addr[p]];
    assign rd_busy[p] = sb_busy[p] & ~byp;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios on a bypass/non-bypass pair plus
// random traffic on 4-slot and 1-slot 32-bit instances against a model.
`timescale 1ns/1ps
module tb_regfile_mp;
  import regfile_pkg::*;

  logic gclk_unused;
  logic clk, rst_n;

  // Pair A (BYPASS=1) and B (BYPASS=0): NSLOT=2, XLEN=64, shared inputs
  logic [1:0]           wr_en, iss_en;
  logic [1:0][4:0]      wr_addr, iss_addr;
  logic [1:0][63:0]     wr_data;
  logic [3:0][4:0]      rd_addr;
  logic [3:0][63:0]     rd_data_a, rd_data_b;
  logic [3:0]           rd_busy_a, rd_busy_b;
  logic                 coll_a, coll_b;

  // C: NSLOT=4, XLEN=32, BYPASS=1; D: NSLOT=1, XLEN=32, BYPASS=0 on C's slot 0
  logic [3:0]           wr_en_c, iss_en_c;
  logic [3:0][4:0]      wr_addr_c, iss_addr_c;
  logic [3:0][31:0]     wr_data_c;
  logic [7:0][4:0]      rd_addr_c;
  logic [7:0][31:0]     rd_data_c;
  logic [7:0]           rd_busy_c;
  logic                 coll_c;
  logic [1:0][31:0]     rd_data_d;
  logic [1:0]           rd_busy_d;
  logic                 coll_d;

  typedef struct {
    int          dut;
    int          port;
    logic [63:0] data;
    logic        busy;
    string       tag;
  } exp_t;
  exp_t expq[$];

  int nchk = 0;
  int nerr = 0;

  logic [63:0] m_reg  [32];
  logic        m_busy [32];
  logic [31:0] mc_reg [32];
  logic        mc_busy[32];
  logic [31:0] md_reg [32];
  logic        md_busy[32];

  regfile_mp #(.XLEN(64), .NREG(32), .NSLOT(2), .BYPASS(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .iss_en(iss_en), .iss_addr(iss_addr), .wr_collide(coll_a));
  regfile_mp #(.XLEN(64), .NREG(32), .NSLOT(2), .BYPASS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .iss_en(iss_en), .iss_addr(iss_addr), .wr_collide(coll_b));
  regfile_mp #(.XLEN(32), .NREG(32), .NSLOT(4), .BYPASS(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
    .iss_en(iss_en_c), .iss_addr(iss_addr_c), .wr_collide(coll_c));
  regfile_mp #(.XLEN(32), .NREG(32), .NSLOT(1), .BYPASS(1'b0)) u_d (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_c[0:0]), .wr_addr(wr_addr_c[0]), .wr_data(wr_data_c[0]),
    .rd_addr(rd_addr_c[1:0]), .rd_data(rd_data_d), .rd_busy(rd_busy_d),
    .iss_en(iss_en_c[0:0]), .iss_addr(iss_addr_c[0]), .wr_collide(coll_d));

  assign gclk_unused = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic logic [64:0] obs(int dut, int p);
    case (dut)
      0:       return {rd_busy_a[p[1:0]], rd_data_a[p[1:0]]};
      1:       return {rd_busy_b[p[1:0]], rd_data_b[p[1:0]]};
      2:       return {rd_busy_c[p[2:0]], 32'h0, rd_data_c[p[2:0]]};
      default: return {rd_busy_d[p[0]], 32'h0, rd_data_d[p[0]]};
    endcase
  endfunction

  task automatic push(int dut, int port, logic [63:0] d, logic b, string tag);
    exp_t e;
    e.dut = dut; e.port = port; e.data = d; e.busy = b; e.tag = tag;
    expq.push_back(e);
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = '0; iss_addr = '0; rd_addr = '0;
    wr_en_c = '0; wr_addr_c = '0; wr_data_c = '0; iss_en_c = '0; iss_addr_c = '0; rd_addr_c = '0;
  endtask

  function automatic logic [64:0] exp_pair(bit byp, int p);
    reg_idx_t a; logic [63:0] d; logic b;
    a = rd_addr[p[1:0]]; d = m_reg[a]; b = m_busy[a];
    if (byp && a != 0)
      for (int i = 0; i < 2; i++)
        if (wr_en[i] && wr_addr[i] == a) begin d = wr_data[i]; b = 1'b0; end
    return {b, d};
  endfunction

  function automatic logic [64:0] exp_c(int p);
    reg_idx_t a; logic [31:0] d; logic b;
    a = rd_addr_c[p[2:0]]; d = mc_reg[a]; b = mc_busy[a];
    if (a != 0)
      for (int i = 0; i < 4; i++)
        if (wr_en_c[i] && wr_addr_c[i] == a) begin d = wr_data_c[i]; b = 1'b0; end
    return {b, 32'h0, d};
  endfunction

  function automatic logic [64:0] exp_d(int p);
    reg_idx_t a;
    a = rd_addr_c[p[2:0]];
    return {md_busy[a], 32'h0, md_reg[a]};
  endfunction

  task automatic test_reset();
    exp_t e; logic [64:0] got;
    idle();
    @(negedge clk);
    wr_en = 2'b11; wr_addr[0] = 5'd3; wr_addr[1] = 5'd3;
    wr_data[0] = 64'h55; wr_data[1] = 64'h66;
    rd_addr = {5'd4, 5'd3, 5'd2, 5'd3};
    for (int p = 0; p < 4; p++) begin push(0, p, 64'h0, 1'b0, "rst_low"); push(1, p, 64'h0, 1'b0, "rst_low"); end
    #2;
    nchk++;
    if (coll_a !== 1'b1) begin nerr++; $display("FAIL rst_collide: got %b, expected 1", coll_a); end
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
    @(negedge clk);
    idle(); rst_n = 1'b1;
    rd_addr[0] = 5'd3;
    push(0, 0, 64'h0, 1'b0, "rst_write_ignored"); push(1, 0, 64'h0, 1'b0, "rst_write_ignored");
    #2;
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
    wr_en = 2'b11; wr_addr[0] = 5'd1; wr_addr[1] = 5'd2;
    wr_data[0] = 64'hAAAA; wr_data[1] = 64'hBBBB;
    iss_en = 2'b01; iss_addr[0] = 5'd3;
    @(negedge clk);
    idle();
    rd_addr = {5'd0, 5'd3, 5'd2, 5'd1};
    push(1, 0, 64'hAAAA, 1'b0, "preload"); push(1, 1, 64'hBBBB, 1'b0, "preload");
    push(1, 2, 64'h0, 1'b1, "preload_busy"); push(1, 3, 64'h0, 1'b0, "preload_x0");
    #2;
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
    #1;
    rst_n = 1'b0;
    wr_en = 2'b01; wr_addr[0] = 5'd1; wr_data[0] = 64'h77;
    #1;
    for (int p = 0; p < 4; p++) begin push(0, p, 64'h0, 1'b0, "rst_async"); push(1, p, 64'h0, 1'b0, "rst_async"); end
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
    @(negedge clk);
    wr_en = '0; rst_n = 1'b1;
    push(0, 0, 64'h0, 1'b0, "rst_edge_ignored"); push(1, 0, 64'h0, 1'b0, "rst_edge_ignored");
    #2;
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
  endtask

  task automatic test_x0();
    exp_t e; logic [64:0] got;
    @(negedge clk);
    idle();
    wr_en = 2'b11; wr_data[0] = 64'hDEAD; wr_data[1] = 64'hBEEF;
    iss_en = 2'b01;
    for (int p = 0; p < 4; p++) begin push(0, p, 64'h0, 1'b0, "x0_same"); push(1, p, 64'h0, 1'b0, "x0_same"); end
    #2;
    nchk++;
    if (coll_a !== 1'b0) begin nerr++; $display("FAIL x0_collide: got %b, expected 0", coll_a); end
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
    @(negedge clk);
    idle();
    for (int p = 0; p < 4; p++) begin push(0, p, 64'h0, 1'b0, "x0_after"); push(1, p, 64'h0, 1'b0, "x0_after"); end
    #2;
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
  endtask

  task automatic test_collision();
    exp_t e; logic [64:0] got;
    @(negedge clk);
    idle();
    wr_en = 2'b11; wr_addr[0] = 5'd5; wr_addr[1] = 5'd5;
    wr_data[0] = 64'h11; wr_data[1] = 64'h22; rd_addr[0] = 5'd5;
    push(0, 0, 64'h22, 1'b0, "coll_bypass"); push(1, 0, 64'h0, 1'b0, "coll_old");
    #2;
    nchk++;
    if (coll_a !== 1'b1 || coll_b !== 1'b1) begin nerr++; $display("FAIL coll_same: got %b/%b, expected 1/1", coll_a, coll_b); end
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
    @(negedge clk);
    wr_addr[1] = 5'd6; wr_data[0] = 64'h33; wr_data[1] = 64'h44; rd_addr[1] = 5'd6;
    push(0, 0, 64'h33, 1'b0, "coll_diff"); push(0, 1, 64'h44, 1'b0, "coll_diff");
    push(1, 0, 64'h22, 1'b0, "coll_winner"); push(1, 1, 64'h0, 1'b0, "coll_diff_old");
    #2;
    nchk++;
    if (coll_a !== 1'b0) begin nerr++; $display("FAIL coll_diff: got %b, expected 0", coll_a); end
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
    @(negedge clk);
    idle(); rd_addr[0] = 5'd5; rd_addr[1] = 5'd6;
    push(1, 0, 64'h33, 1'b0, "coll_after"); push(1, 1, 64'h44, 1'b0, "coll_after");
    #2;
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
  endtask

  task automatic test_bypass();
    exp_t e; logic [64:0] got;
    @(negedge clk);
    idle();
    wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 64'h1234; rd_addr[2] = 5'd7;
    push(0, 2, 64'h1234, 1'b0, "byp_same"); push(1, 2, 64'h0, 1'b0, "nobyp_same");
    #2;
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
    @(negedge clk);
    idle(); rd_addr[2] = 5'd7;
    push(0, 2, 64'h1234, 1'b0, "byp_after"); push(1, 2, 64'h1234, 1'b0, "nobyp_after");
    #2;
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e; logic [64:0] got;
    @(negedge clk);
    idle(); iss_en = 2'b01; iss_addr[0] = 5'd9; rd_addr[1] = 5'd9;
    push(0, 1, 64'h0, 1'b0, "sb_iss_same"); push(1, 1, 64'h0, 1'b0, "sb_iss_same");
    #2;
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
    @(negedge clk);
    idle(); rd_addr[1] = 5'd9;
    push(0, 1, 64'h0, 1'b1, "sb_busy"); push(1, 1, 64'h0, 1'b1, "sb_busy");
    #2;
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
    @(negedge clk);
    iss_en = 2'b01; iss_addr[0] = 5'd9;
    wr_en = 2'b10; wr_addr[1] = 5'd9; wr_data[1] = 64'h99;
    push(0, 1, 64'h99, 1'b0, "sb_wb_iss_byp"); push(1, 1, 64'h0, 1'b1, "sb_wb_iss");
    #2;
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
    @(negedge clk);
    idle(); rd_addr[1] = 5'd9;
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 64'h77;
    push(0, 1, 64'h77, 1'b0, "sb_set_wins_byp"); push(1, 1, 64'h99, 1'b1, "sb_set_wins");
    #2;
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
    @(negedge clk);
    idle(); rd_addr[1] = 5'd9;
    push(0, 1, 64'h77, 1'b0, "sb_cleared"); push(1, 1, 64'h77, 1'b0, "sb_cleared");
    #2;
    while (expq.size() > 0) begin
      e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
      if (got !== {e.busy, e.data}) begin nerr++;
        $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
    end
  endtask

  task automatic test_random_pair();
    exp_t e; logic [64:0] got, x; logic ec;
    @(negedge clk);
    idle(); rst_n = 1'b0;
    for (int r = 0; r < 32; r++) begin m_reg[r] = '0; m_busy[r] = 1'b0; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) begin
      for (int i = 0; i < 2; i++) begin
        wr_en[i] = 1'($urandom); wr_addr[i] = 5'($urandom_range(0, 7));
        wr_data[i] = {$urandom, $urandom};
        iss_en[i] = ($urandom_range(0, 3) == 0); iss_addr[i] = 5'($urandom_range(0, 7));
      end
      for (int p = 0; p < 4; p++) rd_addr[p] = 5'($urandom_range(0, 7));
      for (int p = 0; p < 4; p++) begin
        x = exp_pair(1'b1, p); push(0, p, x[63:0], x[64], "rand_pair");
        x = exp_pair(1'b0, p); push(1, p, x[63:0], x[64], "rand_pair");
      end
      ec = wr_en[0] && wr_en[1] && wr_addr[0] == wr_addr[1] && wr_addr[0] != 0;
      #2;
      nchk++;
      if (coll_a !== ec || coll_b !== ec) begin nerr++; $display("FAIL rand_pair_collide: got %b/%b, expected %b", coll_a, coll_b, ec); end
      while (expq.size() > 0) begin
        e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
        if (got !== {e.busy, e.data}) begin nerr++;
          $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) if (wr_en[i]) m_busy[wr_addr[i]] = 1'b0;
      for (int i = 0; i < 2; i++) if (iss_en[i]) m_busy[iss_addr[i]] = 1'b1;
      for (int i = 0; i < 2; i++) if (wr_en[i] && wr_addr[i] != 0) m_reg[wr_addr[i]] = wr_data[i];
      m_busy[0] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_sweep();
    exp_t e; logic [64:0] got, x; logic ec;
    idle(); rst_n = 1'b0;
    for (int r = 0; r < 32; r++) begin
      mc_reg[r] = '0; mc_busy[r] = 1'b0; md_reg[r] = '0; md_busy[r] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) begin
      for (int i = 0; i < 4; i++) begin
        wr_en_c[i] = 1'($urandom); wr_addr_c[i] = 5'($urandom_range(0, 7));
        wr_data_c[i] = $urandom;
        iss_en_c[i] = ($urandom_range(0, 3) == 0); iss_addr_c[i] = 5'($urandom_range(0, 7));
      end
      for (int p = 0; p < 8; p++) rd_addr_c[p] = 5'($urandom_range(0, 7));
      for (int p = 0; p < 8; p++) begin x = exp_c(p); push(2, p, x[63:0], x[64], "sweep_c"); end
      for (int p = 0; p < 2; p++) begin x = exp_d(p); push(3, p, x[63:0], x[64], "sweep_d"); end
      ec = 1'b0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          if (i != j && wr_en_c[i] && wr_en_c[j] && wr_addr_c[i] == wr_addr_c[j] && wr_addr_c[i] != 0) ec = 1'b1;
      #2;
      nchk++;
      if (coll_c !== ec || coll_d !== 1'b0) begin nerr++; $display("FAIL sweep_collide: got %b/%b, expected %b/0", coll_c, coll_d, ec); end
      while (expq.size() > 0) begin
        e = expq.pop_front(); got = obs(e.dut, e.port); nchk++;
        if (got !== {e.busy, e.data}) begin nerr++;
          $display("FAIL %s dut%0d port%0d: got busy=%b data=%h, expected busy=%b data=%h", e.tag, e.dut, e.port, got[64], got[63:0], e.busy, e.data); end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) if (wr_en_c[i]) mc_busy[wr_addr_c[i]] = 1'b0;
      for (int i = 0; i < 4; i++) if (iss_en_c[i]) mc_busy[iss_addr_c[i]] = 1'b1;
      for (int i = 0; i < 4; i++) if (wr_en_c[i] && wr_addr_c[i] != 0) mc_reg[wr_addr_c[i]] = wr_data_c[i];
      mc_busy[0] = 1'b0;
      if (wr_en_c[0]) md_busy[wr_addr_c[0]] = 1'b0;
      if (iss_en_c[0]) md_busy[iss_addr_c[0]] = 1'b1;
      if (wr_en_c[0] && wr_addr_c[0] != 0) md_reg[wr_addr_c[0]] = wr_data_c[0];
      md_busy[0] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_x0();
    test_collision();
    test_bypass();
    test_scoreboard();
    test_random_pair();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
